bias_act_unit: RTL and testbench
================================

# bias_act_unit

Post-accumulation stage directly downstream of the NPE array. Takes each raw signed accumulator output, adds the per-output-layer bias fetched from bias RAM, and applies optional ReLU, a rounding right-shift and saturation to the output word width. It owns its own pixel/layer counters and bias prefetch, so bias alignment holds even when consecutive layers arrive back-to-back.

## Interface
- DAT_WIDTH, 24: signed NPE accumulator width.
- BIAS_WIDTH, 16: signed bias width; must be ≤ DAT_WIDTH.
- OUT_WIDTH, 8: signed output width.
- ADDR_WIDTH, 7: bias RAM address width.
- i_clk  in  1  clock; one clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_calc_en  in  1  start pulse; clears counters and pipeline, prefetches layer-0 bias.
- i_out_x_length  in  8  pixels per output layer (1..255).
- i_output_layers  in  8  output layers per frame (1..255).
- i_shift  in  5  right-shift amount, 0..DAT_WIDTH-1.
- i_relu_en  in  1  1 = clamp negative sums to 0.
- i_npe_dat_vld  in  1  input pixel strobe.
- i_npe_dat  in  DAT_WIDTH  signed accumulator value.
- o_bias_rd_en  out  1  bias RAM read enable (registered).
- o_bias_addr  out  ADDR_WIDTH  bias RAM address = layer index (registered).
- i_bias_dat  in  BIAS_WIDTH  bias RAM data, valid the cycle after o_bias_rd_en.
- o_dat_vld  out  1  output strobe.
- o_dat  out  OUT_WIDTH  signed result.
- o_frame_done  out  1  one-cycle pulse with the last pixel of the last layer.

## Operation
- Counters: x_cnt (8b) and layer_cnt (8b). Each accepted pixel (i_npe_dat_vld=1, i_calc_en=0) increments x_cnt. At x_cnt == i_out_x_length-1, x_cnt goes to 0 and layer_cnt increments; after i_output_layers-1, layer_cnt wraps to 0. The next frame runs without a new i_calc_en.
- Prefetch: the cycle after i_calc_en, o_bias_rd_en=1 with o_bias_addr=0. The cycle after the last pixel of layer L is accepted, o_bias_rd_en=1 with o_bias_addr = next layer index (0 after the last layer). o_bias_rd_en=0 otherwise.
- bias_reg latches i_bias_dat in the cycle after each read (tracked with a 1-cycle rd_pending flag).
- Pipeline (valid bit, pixel data, last-of-frame tag travel together):
  - S1 registers the input.
  - S2 is an alignment delay.
  - S3 computes sum = sext(S2 data) + sext(bias_reg), DAT_WIDTH+1 bits, registered.
  - S4:
    - if i_relu_en and sum<0, then v=0;
    - v = (v + (i_shift ? 1<<(i_shift-1) : 0)) >>> i_shift, arithmetic shift in DAT_WIDTH+2 bits;
    - saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1];
    - register into o_dat, o_dat_vld and o_frame_done.
- i_calc_en has priority over everything:
  - zeroes the counters and all pipeline valid bits (in-flight pixels are dropped, no o_dat_vld for them);
  - i_npe_dat_vld in the same cycle is ignored;
  - the layer-0 prefetch is issued next.
- i_out_x_length=1 and i_output_layers=1 are legal. Layers may change every cycle; a read is issued every cycle and bias_reg tracks each layer.
- Length or layer count of 0 is unsupported.

## Timing
- Reset: o_dat=0, o_dat_vld=0, o_frame_done=0, o_bias_rd_en=0, o_bias_addr=0, counters=0, bias_reg=0, pipeline valids=0.
- Latency: a pixel sampled at edge e appears on o_dat/o_dat_vld after edge e+3 (4 cycles from its vld cycle). Throughput is 1 pixel/cycle with no bubbles.
- Bias alignment:
  - The first i_npe_dat_vld may be asserted the cycle immediately after i_calc_en.
  - Pixel 0 of layer L+1 may immediately follow the last pixel of layer L.
  - Every pixel is summed with its own layer's bias.
- Bias timing: the bias for a layer is read 1 cycle after that layer's trigger (i_calc_en or the previous layer's last pixel). It is latched 2 cycles after the trigger. It is consumed at S3, 2 cycles after the pixel is accepted.
- i_relu_en and i_shift are quasi-static during a frame; they are sampled combinationally at S4.

## Test plan
- Reset check: assert i_rst_n=0 mid-stream -> all outputs 0 immediately; after release, no o_dat_vld until new valid input.
- x_length=4, layers=2, bias RAM {100,-50}, shift=0, relu off, inputs 0..7 back-to-back right after i_calc_en -> o_dat = 100,101,102,103,-46,-45,-44,-43 (saturated to 127 where needed), starting 4 cycles after the first vld; o_frame_done with the 8th output; reads issued to addr 0, 1, 0.
- x_length=1, layers=3, biases {1,2,3}, input 10 every cycle -> outputs 11,12,13,11,…; o_bias_rd_en high every cycle.
- Rounding and saturation: shift=4, bias 0, inputs 24, -24, 100000, -100000 -> 2, -1, 127, -128. With relu on, the same inputs -> 2, 0, 127, 0.
- Gapped input: random vld gaps with x_length=3, layers=2 -> outputs match the reference model, and the layer tag is never shifted.
- i_calc_en asserted while 3 pixels are in flight -> those pixels produce no output; the next pixel uses the layer-0 bias.

Source files
------------

// File: rtl/bias_act_unit.sv
// Post-accumulation stage: adds per-layer bias, optional ReLU, rounding shift, saturation.
// Latency: pixel sampled at edge e is on o_dat/o_dat_vld after edge e+3; 1 pixel/cycle.
// Backpressure: none; input is a pure strobe and the output must be consumed when valid.
module bias_act_unit #(
   parameter int DAT_WIDTH  = 24,
   parameter int BIAS_WIDTH = 16,
   parameter int OUT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_calc_en,
   input  logic [7:0]                   i_out_x_length,
   input  logic [7:0]                   i_output_layers,
   input  logic [4:0]                   i_shift,
   input  logic                         i_relu_en,
   input  logic                         i_npe_dat_vld,
   input  logic signed [DAT_WIDTH-1:0]  i_npe_dat,
   output logic                         o_bias_rd_en,
   output logic [ADDR_WIDTH-1:0]        o_bias_addr,
   input  logic signed [BIAS_WIDTH-1:0] i_bias_dat,
   output logic                         o_dat_vld,
   output logic signed [OUT_WIDTH-1:0]  o_dat,
   output logic                         o_frame_done
);

   localparam int SUM_W = DAT_WIDTH + 1;
   localparam int EXT_W = DAT_WIDTH + 2;
   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(1 << (OUT_WIDTH - 1)));

   logic [7:0] x_cnt;
   logic [7:0] layer_cnt;
   logic [7:0] last_x;
   logic [7:0] next_layer;
   logic       accept;
   logic       last_layer;
   logic       last_px;

   logic                         rd_pending;
   logic signed [BIAS_WIDTH-1:0] bias_reg;

   logic                         s1_vld, s2_vld, s3_vld;
   logic                         s1_last, s2_last, s3_last;
   logic signed [DAT_WIDTH-1:0]  s1_dat, s2_dat;
   logic signed [SUM_W-1:0]      s3_sum;

   logic signed [EXT_W-1:0]      relu_v;
   logic signed [EXT_W-1:0]      rnd;
   logic signed [EXT_W-1:0]      shifted;
   logic signed [OUT_WIDTH-1:0]  sat_dat;

   // A start pulse swallows any pixel strobe in the same cycle
   assign accept     = i_npe_dat_vld & ~i_calc_en;
   assign last_x     = i_out_x_length - 8'd1;
   assign last_layer = (layer_cnt == i_output_layers - 8'd1);
   assign last_px    = accept && (x_cnt == last_x);
   assign next_layer = last_layer ? 8'd0 : layer_cnt + 8'd1;

   // Pixel and layer position within the frame; frames repeat without a new start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_cnt     <= '0;
         layer_cnt <= '0;
      end else if (i_calc_en) begin
         x_cnt     <= '0;
         layer_cnt <= '0;
      end else if (accept) begin
         if (x_cnt == last_x) begin
            x_cnt     <= '0;
            layer_cnt <= next_layer;
         end else begin
            x_cnt <= x_cnt + 8'd1;
         end
      end
   end

   // Bias prefetch: read layer 0 after a start, next layer right after each layer's last pixel
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_bias_rd_en <= 1'b0;
         o_bias_addr  <= '0;
      end else begin
         o_bias_rd_en <= i_calc_en | last_px;
         if (i_calc_en)
            o_bias_addr <= '0;
         else if (last_px)
            o_bias_addr <= ADDR_WIDTH'(next_layer);
      end
   end

   // Capture the RAM word one cycle after the read; lands just before the new layer's first pixel reaches S3
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_pending <= 1'b0;
         bias_reg   <= '0;
      end else begin
         rd_pending <= o_bias_rd_en;
         if (rd_pending)
            bias_reg <= i_bias_dat;
      end
   end

   // S1 input register and S2 alignment delay; a start flushes all valids
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
         s1_dat  <= '0;
         s2_vld  <= 1'b0;
         s2_last <= 1'b0;
         s2_dat  <= '0;
      end else begin
         s1_vld  <= accept;
         s1_last <= last_px & last_layer;
         if (accept)
            s1_dat <= i_npe_dat;
         s2_vld  <= s1_vld & ~i_calc_en;
         s2_last <= s1_last;
         s2_dat  <= s1_dat;
      end
   end

   // S3 bias add at full precision
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s3_vld  <= 1'b0;
         s3_last <= 1'b0;
         s3_sum  <= '0;
      end else begin
         s3_vld  <= s2_vld & ~i_calc_en;
         s3_last <= s2_last;
         s3_sum  <= {s2_dat[DAT_WIDTH-1], s2_dat}
                  + {{(SUM_W - BIAS_WIDTH){bias_reg[BIAS_WIDTH-1]}}, bias_reg};
      end
   end

   // S4 datapath: ReLU, round-half-up arithmetic shift, clamp to output range
   always_comb begin
      relu_v = {s3_sum[SUM_W-1], s3_sum};
      if (i_relu_en && s3_sum[SUM_W-1])
         relu_v = '0;
      rnd = '0;
      if (i_shift != 5'd0)
         rnd = EXT_W'(1) << (i_shift - 5'd1);
      shifted = (relu_v + rnd) >>> i_shift;
      if (shifted > SAT_MAX)
         sat_dat = SAT_MAX[OUT_WIDTH-1:0];
      else if (shifted < SAT_MIN)
         sat_dat = SAT_MIN[OUT_WIDTH-1:0];
      else
         sat_dat = shifted[OUT_WIDTH-1:0];
   end

   // S4 output register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dat_vld    <= 1'b0;
         o_frame_done <= 1'b0;
         o_dat        <= '0;
      end else begin
         o_dat_vld    <= s3_vld & ~i_calc_en;
         o_frame_done <= s3_vld & s3_last & ~i_calc_en;
         if (s3_vld && !i_calc_en)
            o_dat <= sat_dat;
      end
   end

endmodule

// File: tb/tb_bias_act_unit.sv
// Scoreboard bench for bias_act_unit: models counters, bias RAM and arithmetic.
// Latency: checks each output arrives 4 cycles after its strobe, each read 1 cycle after its trigger.
// Backpressure: none; the bench consumes every output as it appears.
module tb_bias_act_unit;

   logic               i_clk = 1'b0;
   logic               i_rst_n;
   logic               i_calc_en;
   logic [7:0]         i_out_x_length;
   logic [7:0]         i_output_layers;
   logic [4:0]         i_shift;
   logic               i_relu_en;
   logic               i_npe_dat_vld;
   logic signed [23:0] i_npe_dat;
   logic               o_bias_rd_en;
   logic [6:0]         o_bias_addr;
   logic signed [15:0] i_bias_dat;
   logic               o_dat_vld;
   logic signed [7:0]  o_dat;
   logic               o_frame_done;

   always #5 i_clk = ~i_clk;

   bias_act_unit dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_calc_en       (i_calc_en),
      .i_out_x_length  (i_out_x_length),
      .i_output_layers (i_output_layers),
      .i_shift         (i_shift),
      .i_relu_en       (i_relu_en),
      .i_npe_dat_vld   (i_npe_dat_vld),
      .i_npe_dat       (i_npe_dat),
      .o_bias_rd_en    (o_bias_rd_en),
      .o_bias_addr     (o_bias_addr),
      .i_bias_dat      (i_bias_dat),
      .o_dat_vld       (o_dat_vld),
      .o_dat           (o_dat),
      .o_frame_done    (o_frame_done)
   );

   // Synchronous bias RAM: data valid the cycle after the read enable
   logic signed [15:0] bias_mem [128];
   always @(posedge i_clk)
      if (o_bias_rd_en) i_bias_dat <= bias_mem[o_bias_addr];

   typedef struct {
      longint dat;
      bit     done;
      int     stamp;
   } exp_t;

   typedef struct {
      int addr;
      int stamp;
   } rd_t;

   exp_t exp_q[$];
   rd_t  rd_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ncyc  = 0;
   int   mx = 0;
   int   ml = 0;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic longint ref_out(longint d, longint b, bit relu, int sh);
      longint s;
      s = d + b;
      if (relu && s < 0) s = 0;
      if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   // Output and bias-read monitor, sampled on the falling edge
   always @(negedge i_clk) begin
      ncyc++;
      if (i_rst_n) begin
         if (o_dat_vld) begin
            if (exp_q.size() == 0) chk("spurious_vld", o_dat_vld, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("dat", longint'(o_dat), e.dat);
               chk("frame_done", o_frame_done, e.done);
               chk("out_latency", ncyc - e.stamp, 4);
            end
         end
         if (o_bias_rd_en) begin
            if (rd_q.size() == 0) chk("spurious_rd", o_bias_rd_en, 0);
            else begin
               rd_t r;
               r = rd_q.pop_front();
               chk("rd_addr", o_bias_addr, r.addr);
               chk("rd_latency", ncyc - r.stamp, 1);
            end
         end
      end
   end

   // One clock of stimulus; the model is updated at the edge that samples it
   task automatic tick(input bit vld, input bit calc, input int d);
      i_npe_dat_vld = vld;
      i_calc_en     = calc;
      i_npe_dat     = 24'(d);
      @(posedge i_clk);
      if (calc) begin
         exp_q.delete();
         rd_q.delete();
         mx = 0;
         ml = 0;
         rd_q.push_back('{addr: 0, stamp: ncyc});
      end else if (vld) begin
         bit last_x, last_l;
         last_x = (mx == int'(i_out_x_length) - 1);
         last_l = (ml == int'(i_output_layers) - 1);
         exp_q.push_back('{dat: ref_out(d, bias_mem[ml], i_relu_en, int'(i_shift)),
                           done: last_x && last_l, stamp: ncyc});
         if (last_x) begin
            mx = 0;
            ml = last_l ? 0 : ml + 1;
            rd_q.push_back('{addr: ml, stamp: ncyc});
         end else begin
            mx++;
         end
      end
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (exp_q.size() != 0 || rd_q.size() != 0); i++)
         tick(0, 0, 0);
      tick(0, 0, 0);
      chk("drain_out", exp_q.size(), 0);
      chk("drain_rd", rd_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0;
      i_calc_en = 0; i_npe_dat_vld = 0; i_npe_dat = '0;
      i_out_x_length = 8'd4; i_output_layers = 8'd2;
      i_shift = 5'd0; i_relu_en = 1'b0;
      for (int i = 0; i < 128; i++) bias_mem[i] = 16'(i * 3 - 7);
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_dat", o_dat, 0);
      chk("rst_vld", o_dat_vld, 0);
      chk("rst_done", o_frame_done, 0);
      chk("rst_rd_en", o_bias_rd_en, 0);
      chk("rst_addr", o_bias_addr, 0);
      i_rst_n = 1'b1;
      repeat (2) tick(0, 0, 0);

      // Two layers of four pixels, back-to-back right after the start pulse
      bias_mem[0] = 100; bias_mem[1] = -50;
      tick(0, 1, 0);
      for (int i = 0; i < 8; i++) tick(1, 0, i);
      drain();

      // One pixel per layer: a bias read every cycle
      i_out_x_length = 8'd1; i_output_layers = 8'd3;
      bias_mem[0] = 1; bias_mem[1] = 2; bias_mem[2] = 3;
      tick(0, 1, 0);
      for (int i = 0; i < 9; i++) tick(1, 0, 10);
      drain();

      // Rounding and saturation, ReLU off then on
      i_out_x_length = 8'd4; i_output_layers = 8'd1;
      bias_mem[0] = 0; i_shift = 5'd4;
      for (int r = 0; r < 2; r++) begin
         i_relu_en = r[0];
         tick(0, 1, 0);
         tick(1, 0, 24);
         tick(1, 0, -24);
         tick(1, 0, 100000);
         tick(1, 0, -100000);
         drain();
      end

      // Random gaps, then an asynchronous reset with pixels in flight
      i_out_x_length = 8'd3; i_output_layers = 8'd2;
      bias_mem[0] = 37; bias_mem[1] = -1234; i_relu_en = 1'b0;
      tick(0, 1, 0);
      for (int i = 0; i < 40; i++)
         tick(($urandom_range(0, 9) < 6), 0, int'($urandom_range(0, 6000)) - 3000);
      for (int i = 0; i < 3; i++) tick(1, 0, 500 + i * 100);
      i_rst_n = 1'b0;
      #1;
      chk("midrst_dat", o_dat, 0);
      chk("midrst_vld", o_dat_vld, 0);
      chk("midrst_done", o_frame_done, 0);
      chk("midrst_rd_en", o_bias_rd_en, 0);
      chk("midrst_addr", o_bias_addr, 0);
      exp_q.delete(); rd_q.delete(); mx = 0; ml = 0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      repeat (6) tick(0, 0, 0);

      // Start pulse with three pixels in flight and a strobe in the same cycle
      i_out_x_length = 8'd4; i_output_layers = 8'd2; i_shift = 5'd0;
      bias_mem[0] = 100; bias_mem[1] = -50;
      tick(0, 1, 0);
      for (int i = 0; i < 6; i++) tick(1, 0, i);
      tick(1, 1, 99);
      tick(1, 0, 20);
      tick(1, 0, 21);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
